// File: rtl/noc_params.sv
// noc_params: shared router port encoding
package noc_params;
    typedef enum logic [2:0] {CENTER, LEFT, RIGHT, UP, DOWN} port_t;
endpackage

// File: rtl/rc_vc_unit.sv
// rc_vc_unit: per-VC route computation, held registered from head capture until release
module rc_vc_unit
    import noc_params::*;
#(
    parameter int MESH_SIZE_X = 4,
    parameter int MESH_SIZE_Y = 4,
    parameter int X_CURRENT = 0,
    parameter int Y_CURRENT = 0,
    parameter int VC_NUM = 2,
    parameter int ROUTING_MODE = 0,
    parameter int DEST_X_SIZE = $clog2(MESH_SIZE_X),
    parameter int DEST_Y_SIZE = $clog2(MESH_SIZE_Y),
    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flit_valid,
    input  logic [VC_W-1:0]        flit_vc,
    input  logic                   flit_is_head,
    input  logic [DEST_X_SIZE-1:0] x_dest,
    input  logic [DEST_Y_SIZE-1:0] y_dest,
    input  logic [VC_NUM-1:0]      vc_release,
    output logic [VC_NUM-1:0]      route_valid,
    output port_t                  out_port [VC_NUM-1:0],
    output logic [VC_NUM-1:0]      dest_err,
    output logic                   proto_err
);
    typedef enum logic {IDLE, ROUTED} state_t;

    localparam logic signed [DEST_X_SIZE:0] XC = (DEST_X_SIZE+1)'(X_CURRENT);
    localparam logic signed [DEST_Y_SIZE:0] YC = (DEST_Y_SIZE+1)'(Y_CURRENT);

    state_t state [VC_NUM-1:0];
    logic [VC_NUM-1:0] head_hit, routed;
    logic signed [DEST_X_SIZE:0] dx;
    logic signed [DEST_Y_SIZE:0] dy;
    logic oom;
    port_t xp, yp, route;

    assign dx = $signed({1'b0, x_dest}) - XC;
    assign dy = $signed({1'b0, y_dest}) - YC;
    assign oom = ({1'b0, x_dest} >= (DEST_X_SIZE+1)'(MESH_SIZE_X)) |
                 ({1'b0, y_dest} >= (DEST_Y_SIZE+1)'(MESH_SIZE_Y));
    assign xp = dx[DEST_X_SIZE] ? LEFT : RIGHT;
    assign yp = dy[DEST_Y_SIZE] ? UP : DOWN;
    assign route = oom ? CENTER :
                   (ROUTING_MODE == 0) ? ((|dx) ? xp : (|dy) ? yp : CENTER)
                                       : ((|dy) ? yp : (|dx) ? xp : CENTER);
    assign route_valid = routed;

    always_comb begin
        head_hit = '0;
        routed = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            head_hit[v] = flit_valid & flit_is_head & (flit_vc == VC_W'(v));
            routed[v] = state[v] == ROUTED;
        end
    end

    // a same-cycle release frees the VC for the incoming head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state[v] <= IDLE;
                out_port[v] <= CENTER;
            end
            dest_err <= '0;
            proto_err <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (head_hit[v] && (!routed[v] || vc_release[v])) begin
                    state[v] <= ROUTED;
                    out_port[v] <= route;
                    dest_err[v] <= oom;
                end else if (vc_release[v]) begin
                    state[v] <= IDLE;
                    out_port[v] <= CENTER;
                    dest_err[v] <= 1'b0;
                end
            end
            if (|(head_hit & routed & ~vc_release))
                proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rc_vc_unit.sv
// tb_rc_vc_unit: directed table, corner sequences and random run against a behavioural model
module tb_rc_vc_unit;
    import noc_params::*;

    logic clk = 1'b0;
    logic rst;
    logic fv, hd;
    logic [1:0] vc;
    logic [2:0] xd, yd, rel;

    logic [1:0] rv_a, de_a, rv_b, de_b;
    logic [2:0] rv_c, de_c;
    port_t op_a [1:0];
    port_t op_b [1:0];
    port_t op_c [2:0];
    logic pe_a, pe_b, pe_c;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rc_vc_unit #(.X_CURRENT(1), .Y_CURRENT(1), .VC_NUM(2), .ROUTING_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .flit_valid(fv), .flit_vc(vc[0]), .flit_is_head(hd),
        .x_dest(xd[1:0]), .y_dest(yd[1:0]), .vc_release(rel[1:0]),
        .route_valid(rv_a), .out_port(op_a), .dest_err(de_a), .proto_err(pe_a));

    rc_vc_unit #(.X_CURRENT(1), .Y_CURRENT(1), .VC_NUM(2), .ROUTING_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .flit_valid(fv), .flit_vc(vc[0]), .flit_is_head(hd),
        .x_dest(xd[1:0]), .y_dest(yd[1:0]), .vc_release(rel[1:0]),
        .route_valid(rv_b), .out_port(op_b), .dest_err(de_b), .proto_err(pe_b));

    rc_vc_unit #(.X_CURRENT(0), .Y_CURRENT(0), .VC_NUM(3), .ROUTING_MODE(0),
                 .DEST_X_SIZE(3), .DEST_Y_SIZE(3)) dut_c (
        .clk(clk), .rst(rst), .flit_valid(fv), .flit_vc(vc), .flit_is_head(hd),
        .x_dest(xd), .y_dest(yd), .vc_release(rel),
        .route_valid(rv_c), .out_port(op_c), .dest_err(de_c), .proto_err(pe_c));

    // reference model: per instance, per VC route record
    int cx [3] = '{1, 1, 0};
    int cy [3] = '{1, 1, 0};
    int md [3] = '{0, 1, 0};
    int nvc [3] = '{2, 2, 3};
    bit m_v [3][3];
    bit m_e [3][3];
    port_t m_p [3][3];
    bit m_pe [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pe[i] = 0;
            for (int v = 0; v < 3; v++) begin
                m_v[i][v] = 0;
                m_e[i][v] = 0;
                m_p[i][v] = CENTER;
            end
        end
    endtask

    function automatic port_t model_route(int i, int x, int y);
        int dx = x - cx[i];
        int dy = y - cy[i];
        port_t px = dx < 0 ? LEFT : RIGHT;
        port_t py = dy < 0 ? UP : DOWN;
        if (x >= 4 || y >= 4) return CENTER;
        if (md[i] == 0) return dx != 0 ? px : dy != 0 ? py : CENTER;
        return dy != 0 ? py : dx != 0 ? px : CENTER;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int sv = (i < 2) ? int'(vc[0]) : int'(vc);
            int sx = (i < 2) ? int'(xd[1:0]) : int'(xd);
            int sy = (i < 2) ? int'(yd[1:0]) : int'(yd);
            for (int v = 0; v < nvc[i]; v++) begin
                bit hit = fv && hd && sv == v;
                if (hit && m_v[i][v] && !rel[v]) m_pe[i] = 1;
                else if (hit) begin
                    m_v[i][v] = 1;
                    m_e[i][v] = sx >= 4 || sy >= 4;
                    m_p[i][v] = model_route(i, sx, sy);
                end else if (rel[v]) begin
                    m_v[i][v] = 0;
                    m_e[i][v] = 0;
                    m_p[i][v] = CENTER;
                end
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_rv(int i, int v);
        case (i)
            0: return 32'(rv_a[v]);
            1: return 32'(rv_b[v]);
            default: return 32'(rv_c[v]);
        endcase
    endfunction

    function automatic logic [31:0] dut_de(int i, int v);
        case (i)
            0: return 32'(de_a[v]);
            1: return 32'(de_b[v]);
            default: return 32'(de_c[v]);
        endcase
    endfunction

    function automatic logic [31:0] dut_op(int i, int v);
        case (i)
            0: return 32'(op_a[v]);
            1: return 32'(op_b[v]);
            default: return 32'(op_c[v]);
        endcase
    endfunction

    function automatic logic [31:0] dut_pe(int i);
        return i == 0 ? 32'(pe_a) : i == 1 ? 32'(pe_b) : 32'(pe_c);
    endfunction

    task automatic check_model(int cyc);
        for (int i = 0; i < 3; i++) begin
            for (int v = 0; v < nvc[i]; v++) begin
                chk($sformatf("rnd c%0d dut%0d vc%0d route_valid", cyc, i, v), dut_rv(i, v), 32'(m_v[i][v]));
                chk($sformatf("rnd c%0d dut%0d vc%0d dest_err", cyc, i, v), dut_de(i, v), 32'(m_e[i][v]));
                chk($sformatf("rnd c%0d dut%0d vc%0d out_port", cyc, i, v), dut_op(i, v), 32'(m_p[i][v]));
            end
            chk($sformatf("rnd c%0d dut%0d proto_err", cyc, i), dut_pe(i), 32'(m_pe[i]));
        end
    endtask

    task automatic drive(bit f, bit h, bit [1:0] c, bit [2:0] x, bit [2:0] y, bit [2:0] r);
        fv = f; hd = h; vc = c; xd = x; yd = y; rel = r;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit f, h;
        bit [1:0] c;
        bit [2:0] x, y, r;
        bit [1:0] rv;
        port_t p0a, p1a, p0b;
        bit pe;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // routers A (XY) and B (YX) both at (1,1)
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 3'd3, 3'd0, 3'b000, 2'b01, RIGHT,  CENTER, UP,     1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 3'b000, 2'b01, RIGHT,  CENTER, UP,     1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'b001, 2'b00, CENTER, CENTER, CENTER, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 2'd0, 3'd1, 3'd3, 3'b000, 2'b01, DOWN,   CENTER, DOWN,   1'b0};
        tbl[4]  = '{1'b1, 1'b1, 2'd1, 3'd1, 3'd1, 3'b001, 2'b10, CENTER, CENTER, CENTER, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 2'd0, 3'd0, 3'd1, 3'b000, 2'b11, LEFT,   CENTER, LEFT,   1'b0};
        tbl[6]  = '{1'b1, 1'b1, 2'd0, 3'd3, 3'd3, 3'b001, 2'b11, RIGHT,  CENTER, DOWN,   1'b0};
        tbl[7]  = '{1'b1, 1'b1, 2'd0, 3'd0, 3'd0, 3'b000, 2'b11, RIGHT,  CENTER, DOWN,   1'b1};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'b011, 2'b00, CENTER, CENTER, CENTER, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 2'd1, 3'd1, 3'd0, 3'b000, 2'b10, CENTER, UP,     CENTER, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 2'd0, 3'd2, 3'd2, 3'b001, 2'b10, CENTER, UP,     CENTER, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 2'd0, 3'd0, 3'd2, 3'b010, 2'b01, LEFT,   CENTER, DOWN,   1'b1};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("reset route_valid", 32'(rv_a), 0);
        chk("reset out_port", 32'(op_a[0]), 32'(CENTER));
        chk("reset dest_err", 32'(de_c), 0);
        chk("reset proto_err", 32'(pe_a), 0);
        rst = 1'b0;

        for (int k = 0; k < 12; k++) begin
            drive(tbl[k].f, tbl[k].h, tbl[k].c, tbl[k].x, tbl[k].y, tbl[k].r);
            step();
            chk($sformatf("vec%0d route_valid", k), 32'(rv_a), 32'(tbl[k].rv));
            chk($sformatf("vec%0d a out_port0", k), 32'(op_a[0]), 32'(tbl[k].p0a));
            chk($sformatf("vec%0d a out_port1", k), 32'(op_a[1]), 32'(tbl[k].p1a));
            chk($sformatf("vec%0d b out_port0", k), 32'(op_b[0]), 32'(tbl[k].p0b));
            chk($sformatf("vec%0d proto_err", k), 32'(pe_a), 32'(tbl[k].pe));
        end

        // asynchronous reset mid-packet, between edges
        drive(1, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("async rst route_valid", 32'(rv_a), 0);
        chk("async rst out_port", 32'(op_a[0]), 32'(CENTER));
        chk("async rst proto_err", 32'(pe_a), 0);
        chk("async rst route_valid c", 32'(rv_c), 0);
        rst = 1'b0;
        model_reset();

        drive(1, 1, 0, 0, 1, 0);
        step();
        chk("post rst head rv", 32'(rv_a), 32'h1);
        chk("post rst head port", 32'(op_a[0]), 32'(LEFT));
        drive(1, 1, 1, 1, 3, 0);
        step();
        chk("vc1 head rv", 32'(rv_a), 32'h3);
        chk("vc1 head port", 32'(op_a[1]), 32'(DOWN));
        drive(0, 0, 0, 0, 0, 3'b010);
        step();
        chk("rel vc1 rv", 32'(rv_a), 32'h1);
        chk("rel vc1 port0 held", 32'(op_a[0]), 32'(LEFT));
        chk("rel vc1 port1", 32'(op_a[1]), 32'(CENTER));

        // out-of-mesh destination on the 3-bit field router at (0,0)
        drive(1, 1, 0, 4, 0, 3'b001);
        step();
        chk("oom rv", 32'(rv_c), 32'h1);
        chk("oom dest_err", 32'(de_c), 32'h1);
        chk("oom port", 32'(op_c[0]), 32'(CENTER));
        chk("oom proto_err", 32'(pe_c), 0);
        drive(0, 0, 0, 0, 0, 3'b001);
        step();
        chk("oom rel rv", 32'(rv_c), 0);
        chk("oom rel dest_err", 32'(de_c), 0);
        drive(1, 1, 3, 1, 0, 0);
        step();
        chk("vc out of range rv", 32'(rv_c), 0);
        chk("vc out of range proto", 32'(pe_c), 0);
        drive(1, 1, 2, 2, 3, 0);
        step();
        chk("vc2 head rv", 32'(rv_c), 32'h4);
        chk("vc2 head port", 32'(op_c[2]), 32'(RIGHT));

        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                  {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
            step();
            check_model(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
